// File: rtl/pipe_ctrl_pkg.sv
// Shared control-word layout and constants for the back-end control pipeline.
// Pure definitions; no latency and no flow control.
package pipe_ctrl_pkg;

    localparam int CTRL_W_DEF = 8;

    // Bit positions inside the decoded control word.
    typedef enum int {
        REGWRITE  = 0,
        MEMREAD   = 1,
        MEMWRITE  = 2,
        RESULTSRC = 3,
        ALUSRC    = 4,
        IMMSRC_LO = 5,
        IMMSRC_HI = 6,
        HALT      = 7
    } ctrl_bit_e;

    localparam logic [CTRL_W_DEF-1:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register (valid + ctrl + tgt); 1-cycle latency.
// hold freezes the stage, clear loads a bubble and wins over hold.
module ctrl_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int TGT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              clear,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [TGT_W-1:0]  d_tgt,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [TGT_W-1:0]  q_tgt
);

    // Payload is masked on load so an invalid stage never carries stale fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_W'(BUBBLE);
            q_tgt   <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_W'(BUBBLE);
            q_tgt   <= '0;
        end else if (!hold) begin
            q_valid <= d_valid;
            q_ctrl  <= d_valid ? d_ctrl : CTRL_W'(BUBBLE);
            q_tgt   <= d_valid ? d_tgt : '0;
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// N-stage control-word pipeline with stall bubbles, depth-limited flush, sticky halt drain.
// Input reaches stage k after k+1 cycles; stall holds the low stages, no ready handshake.
module ctrl_pipe_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int TGT_W      = 8,
    parameter int STALL_LAST = 0,
    parameter int FLUSH_LAST = 0,
    parameter int HALT_BIT   = int'(HALT),
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [TGT_W-1:0]             in_tgt,
    input  logic                         stall,
    input  logic                         flush,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*CTRL_W-1:0]     stage_ctrl,
    output logic [STAGES*TGT_W-1:0]      stage_tgt,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic                         halted,
    output logic [CNT_W-1:0]             bubble_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int OCC_W = $clog2(STAGES + 1);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "ctrl_pipe_chain: STAGES must be >= 2");
    end
    if (STALL_LAST < 0 || STALL_LAST > STAGES - 2) begin : g_bad_stall
        $fatal(1, "ctrl_pipe_chain: STALL_LAST out of range");
    end
    if (FLUSH_LAST < 0 || FLUSH_LAST > STAGES - 1) begin : g_bad_flush
        $fatal(1, "ctrl_pipe_chain: FLUSH_LAST out of range");
    end
    if (HALT_BIT < 0 || HALT_BIT >= CTRL_W) begin : g_bad_halt
        $fatal(1, "ctrl_pipe_chain: HALT_BIT outside control word");
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] hld;
    logic [STAGES-1:0] clr;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [TGT_W-1:0]  tgt_q  [STAGES];
    logic              halt_seen;
    logic              stage0_bubble;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic IN_FLUSH  = (k <= FLUSH_LAST);
        localparam logic IN_STALL  = (k <= STALL_LAST);
        localparam logic STALL_BUB = (k == STALL_LAST + 1);

        logic              d_valid;
        logic [CTRL_W-1:0] d_ctrl;
        logic [TGT_W-1:0]  d_tgt;

        if (k == 0) begin : g_head
            // Once halted, decode is cut off and only bubbles enter.
            assign d_valid = in_valid & ~halted;
            assign d_ctrl  = in_ctrl;
            assign d_tgt   = in_tgt;
        end else begin : g_body
            assign d_valid = vld_q[k-1];
            assign d_ctrl  = ctrl_q[k-1];
            assign d_tgt   = tgt_q[k-1];
        end

        // Flush overrides stall entirely, including the stall hold.
        assign clr[k] = flush ? IN_FLUSH : (stall & STALL_BUB);
        assign hld[k] = ~flush & stall & IN_STALL;

        ctrl_stage_reg #(
            .CTRL_W (CTRL_W),
            .TGT_W  (TGT_W)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .hold    (hld[k]),
            .clear   (clr[k]),
            .d_valid (d_valid),
            .d_ctrl  (d_ctrl),
            .d_tgt   (d_tgt),
            .q_valid (vld_q[k]),
            .q_ctrl  (ctrl_q[k]),
            .q_tgt   (tgt_q[k])
        );

        assign stage_ctrl[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        assign stage_tgt[k*TGT_W +: TGT_W]    = tgt_q[k];
    end

    assign stage_valid = vld_q;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(vld_q[i]);
        end
    end

    assign halt_seen = vld_q[STAGES-1] & ctrl_q[STAGES-1][HALT_BIT];

    // Stage 0 always holds on stall, so a stall cycle never loads a bubble there.
    assign stage0_bubble = flush | (~stall & (~in_valid | halted));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted     <= 1'b0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (halt_seen) begin
                halted <= 1'b1;
            end
            if (stage0_bubble && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain: default, FLUSH_LAST=1 and CNT_W=4 instances on shared inputs.
module tb_ctrl_pipe_chain;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_ctrl;
    logic [7:0] in_tgt;
    logic       stall;
    logic       flush;

    logic [2:0]  a_vld, b_vld, c_vld;
    logic [23:0] a_ctrl, b_ctrl, c_ctrl;
    logic [23:0] a_tgt, b_tgt, c_tgt;
    logic [1:0]  a_occ, b_occ, c_occ;
    logic        a_halt, b_halt, c_halt;
    logic [15:0] a_bub, b_bub, a_flc, b_flc;
    logic [3:0]  c_bub, c_flc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe_chain u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_tgt(in_tgt),
        .stall(stall), .flush(flush), .stage_valid(a_vld), .stage_ctrl(a_ctrl),
        .stage_tgt(a_tgt), .occupancy(a_occ), .halted(a_halt), .bubble_cnt(a_bub),
        .flush_cnt(a_flc)
    );

    ctrl_pipe_chain #(.FLUSH_LAST(1)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_tgt(in_tgt),
        .stall(stall), .flush(flush), .stage_valid(b_vld), .stage_ctrl(b_ctrl),
        .stage_tgt(b_tgt), .occupancy(b_occ), .halted(b_halt), .bubble_cnt(b_bub),
        .flush_cnt(b_flc)
    );

    ctrl_pipe_chain #(.CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_tgt(in_tgt),
        .stall(stall), .flush(flush), .stage_valid(c_vld), .stage_ctrl(c_ctrl),
        .stage_tgt(c_tgt), .occupancy(c_occ), .halted(c_halt), .bubble_cnt(c_bub),
        .flush_cnt(c_flc)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  ic;
        logic [7:0]  it;
        logic        st;
        logic        fl;
        logic [2:0]  vld;
        logic [23:0] ctrl;
        logic [23:0] tgt;
        logic [1:0]  occ;
        logic [15:0] bub;
        logic [15:0] flc;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic iv, input logic [7:0] ic, input logic [7:0] it,
                                input logic st, input logic fl, input logic [2:0] vld,
                                input logic [23:0] ctrl, input logic [23:0] tgt,
                                input logic [1:0] occ, input logic [15:0] bub,
                                input logic [15:0] flc);
        vec_t v;
        v.iv = iv; v.ic = ic; v.it = it; v.st = st; v.fl = fl;
        v.vld = vld; v.ctrl = ctrl; v.tgt = tgt; v.occ = occ; v.bub = bub; v.flc = flc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] ic, input logic [7:0] it,
                         input logic st, input logic fl);
        in_valid = iv; in_ctrl = ic; in_tgt = it; stall = st; flush = fl;
    endtask

    task automatic step(input logic iv, input logic [7:0] ic, input logic [7:0] it,
                        input logic st, input logic fl);
        drive(iv, ic, it, st, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(a_vld), 32'h0);
        chk("rst_ctrl", 32'(a_ctrl), 32'h0);
        chk("rst_tgt", 32'(a_tgt), 32'h0);
        chk("rst_occ", 32'(a_occ), 32'h0);
        chk("rst_halt", 32'(a_halt), 32'h0);
        chk("rst_bub", 32'(a_bub), 32'h0);
        chk("rst_flc", 32'(a_flc), 32'h0);
        reset = 1'b1;

        // Default instance: STALL_LAST=0, FLUSH_LAST=0.
        vecs[0]  = mk(1, 8'h01, 8'h51, 0, 0, 3'b001, 24'h000001, 24'h000051, 2'd1, 16'd0, 16'd0);
        vecs[1]  = mk(1, 8'h02, 8'h52, 0, 0, 3'b011, 24'h000102, 24'h005152, 2'd2, 16'd0, 16'd0);
        vecs[2]  = mk(1, 8'h03, 8'h53, 0, 0, 3'b111, 24'h010203, 24'h515253, 2'd3, 16'd0, 16'd0);
        vecs[3]  = mk(0, 8'h00, 8'h00, 0, 0, 3'b110, 24'h020300, 24'h525300, 2'd2, 16'd1, 16'd0);
        vecs[4]  = mk(1, 8'h22, 8'h72, 0, 0, 3'b101, 24'h030022, 24'h530072, 2'd2, 16'd1, 16'd0);
        vecs[5]  = mk(1, 8'h11, 8'h61, 0, 0, 3'b011, 24'h002211, 24'h007261, 2'd2, 16'd1, 16'd0);
        vecs[6]  = mk(1, 8'h33, 8'h83, 1, 0, 3'b101, 24'h220011, 24'h720061, 2'd2, 16'd1, 16'd0);
        vecs[7]  = mk(1, 8'h33, 8'h83, 0, 0, 3'b011, 24'h001133, 24'h006183, 2'd2, 16'd1, 16'd0);
        vecs[8]  = mk(1, 8'h44, 8'h94, 0, 1, 3'b110, 24'h113300, 24'h618300, 2'd2, 16'd2, 16'd1);
        vecs[9]  = mk(1, 8'h55, 8'hA5, 1, 1, 3'b100, 24'h330000, 24'h830000, 2'd1, 16'd3, 16'd2);
        vecs[10] = mk(0, 8'h00, 8'h00, 1, 0, 3'b000, 24'h000000, 24'h000000, 2'd0, 16'd3, 16'd2);
        vecs[11] = mk(1, 8'h66, 8'hB6, 0, 0, 3'b001, 24'h000066, 24'h0000B6, 2'd1, 16'd3, 16'd2);
        vecs[12] = mk(0, 8'h77, 8'hC7, 0, 0, 3'b010, 24'h006600, 24'h00B600, 2'd1, 16'd4, 16'd2);
        vecs[13] = mk(0, 8'h00, 8'h00, 0, 0, 3'b100, 24'h660000, 24'hB60000, 2'd1, 16'd5, 16'd2);
        vecs[14] = mk(0, 8'h00, 8'h00, 0, 0, 3'b000, 24'h000000, 24'h000000, 2'd0, 16'd6, 16'd2);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].iv, vecs[i].ic, vecs[i].it, vecs[i].st, vecs[i].fl);
            chk($sformatf("vec%0d_vld", i), 32'(a_vld), 32'(vecs[i].vld));
            chk($sformatf("vec%0d_ctrl", i), 32'(a_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d_tgt", i), 32'(a_tgt), 32'(vecs[i].tgt));
            chk($sformatf("vec%0d_occ", i), 32'(a_occ), 32'(vecs[i].occ));
            chk($sformatf("vec%0d_bub", i), 32'(a_bub), 32'(vecs[i].bub));
            chk($sformatf("vec%0d_flc", i), 32'(a_flc), 32'(vecs[i].flc));
            chk($sformatf("vec%0d_halt", i), 32'(a_halt), 32'h0);
        end

        // Asynchronous reset in the middle of a full pipe.
        do_reset();
        step(1, 8'h01, 8'h11, 0, 0);
        step(1, 8'h02, 8'h12, 0, 0);
        step(1, 8'h03, 8'h13, 0, 0);
        chk("mid_full_vld", 32'(a_vld), 32'h7);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(a_vld), 32'h0);
        chk("mid_rst_ctrl", 32'(a_ctrl), 32'h0);
        chk("mid_rst_tgt", 32'(a_tgt), 32'h0);
        chk("mid_rst_occ", 32'(a_occ), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // FLUSH_LAST=1: flush alone, then flush with stall, from the same fill.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            step(1, 8'h0C, 8'h3C, 0, 0);
            step(1, 8'h0B, 8'h3B, 0, 0);
            step(1, 8'h0A, 8'h3A, 0, 0);
            step(1, 8'h0D, 8'h3D, m[0], 1);
            chk($sformatf("fl%0d_b_vld", m), 32'(b_vld), 32'h4);
            chk($sformatf("fl%0d_b_ctrl", m), 32'(b_ctrl), 32'h0B0000);
            chk($sformatf("fl%0d_b_tgt", m), 32'(b_tgt), 32'h3B0000);
            chk($sformatf("fl%0d_b_flc", m), 32'(b_flc), 32'h1);
            chk($sformatf("fl%0d_b_bub", m), 32'(b_bub), 32'h1);
            chk($sformatf("fl%0d_a_ctrl", m), 32'(a_ctrl), 32'h0B0A00);
            chk($sformatf("fl%0d_a_vld", m), 32'(a_vld), 32'h6);
        end

        // Halt word followed by a continuous stream: halt sets 4 edges after issue, then drains.
        do_reset();
        step(1, 8'h80, 8'h90, 0, 0);
        step(1, 8'h01, 8'h91, 0, 0);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_e3_ctrl", 32'(a_ctrl), 32'h800101);
        chk("halt_e3_halted", 32'(a_halt), 32'h0);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_e4_halted", 32'(a_halt), 32'h1);
        chk("halt_e4_ctrl", 32'(a_ctrl), 32'h010101);
        chk("halt_e4_bub", 32'(a_bub), 32'h0);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_e5_vld", 32'(a_vld), 32'h6);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_e6_vld", 32'(a_vld), 32'h4);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_e7_vld", 32'(a_vld), 32'h0);
        chk("halt_e7_occ", 32'(a_occ), 32'h0);
        chk("halt_e7_bub", 32'(a_bub), 32'h3);
        step(1, 8'h01, 8'h91, 0, 0);
        chk("halt_sticky", 32'(a_halt), 32'h1);
        chk("halt_sticky_vld", 32'(a_vld), 32'h0);

        // Saturation of the 4-bit counters.
        do_reset();
        chk("sat_rst_halt", 32'(a_halt), 32'h0);
        for (int n = 1; n <= 20; n++) begin
            step(0, 8'h00, 8'h00, 0, 0);
            if (n == 14) chk("sat_bub14", 32'(c_bub), 32'd14);
            if (n == 15) chk("sat_bub15", 32'(c_bub), 32'd15);
        end
        chk("sat_bub20", 32'(c_bub), 32'd15);
        chk("wide_bub20", 32'(a_bub), 32'd20);
        for (int n = 1; n <= 17; n++) begin
            step(0, 8'h00, 8'h00, 0, 1);
            if (n == 14) chk("sat_flc14", 32'(c_flc), 32'd14);
        end
        chk("sat_flc17", 32'(c_flc), 32'd15);
        chk("wide_flc17", 32'(a_flc), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
